wavetable_player: RTL and testbench



---
 rtl/wave_pkg.sv | 14 +
 rtl/phase_acc.sv | 54 +++++
 rtl/wavetable_player.sv | 174 +++++++++++++++++
 tb/tb_wavetable_player.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared constants and types for the wavetable playback path.
package wave_pkg;

  localparam int unsigned DEF_WW_WIDTH   = 18;
  localparam int unsigned DEF_FRAC_WIDTH = 12;
  localparam int unsigned DEF_PH_W       = DEF_WW_WIDTH + DEF_FRAC_WIDTH;
  // BRAM port-B address-to-data delay with the output register enabled.
  localparam int unsigned READ_LATENCY   = 2;

  typedef enum logic {MUTE, RUN} state_e;

  typedef logic [DEF_PH_W-1:0] phase_t;

endpackage

// File: rtl/phase_acc.sv
// One oscillator's fixed-point phase accumulator with wrap at the wave width.
// A sum that still lands past the limit after one subtraction clamps to 0.
module phase_acc
  import wave_pkg::*;
#(
  parameter int unsigned WW_WIDTH   = DEF_WW_WIDTH,
  parameter int unsigned FRAC_WIDTH = DEF_FRAC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           advance,
  input  logic                           enable,
  input  logic [WW_WIDTH+FRAC_WIDTH-1:0] step,
  input  logic [WW_WIDTH-1:0]            wave_width,
  output logic [WW_WIDTH-1:0]            index
);

  localparam int unsigned PH_W = WW_WIDTH + FRAC_WIDTH;

  logic [PH_W-1:0] phase_q, phase_d;
  logic [PH_W:0]   sum, limit, reduced;

  // Next phase: clear wins, then tick advance with single-step wrap.
  always_comb begin
    sum     = {1'b0, phase_q} + {1'b0, step};
    limit   = {1'b0, wave_width, {FRAC_WIDTH{1'b0}}};
    reduced = sum - limit;
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (advance) begin
      if (!enable || (wave_width == '0)) begin
        phase_d = '0;
      end else if (sum >= limit) begin
        phase_d = (reduced >= limit) ? '0 : reduced[PH_W-1:0];
      end else begin
        phase_d = sum[PH_W-1:0];
      end
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign index = phase_q[PH_W-1:FRAC_WIDTH];

endmodule

// File: rtl/wavetable_player.sv
// Wavetable playback: per-oscillator phase accumulators drive BRAM read
// addresses; read data is captured after the BRAM latency and presented with
// a one-cycle valid strobe. Optional feature macro: MIXER_EN adds mix_out.
module wavetable_player
  import wave_pkg::*;
#(
  parameter int unsigned NUM_OSCILLATORS = 4,
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned WW_WIDTH        = DEF_WW_WIDTH,
  parameter int unsigned FRAC_WIDTH      = DEF_FRAC_WIDTH
) (
  input  logic                                           clk_in,
  input  logic                                           rst_in,
  input  logic                                           sample_tick_in,
  input  logic [WW_WIDTH-1:0]                            wave_width_in,
  input  logic                                           reload_in,
  input  logic                                           loading_in,
  input  logic [NUM_OSCILLATORS-1:0]                     osc_is_on_in,
  input  logic [NUM_OSCILLATORS*(WW_WIDTH+FRAC_WIDTH)-1:0] osc_step_in,
  output logic [NUM_OSCILLATORS*WW_WIDTH-1:0]            osc_index_out,
  input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0]        osc_data_in,
  output logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0]        osc_sample_out,
  output logic                                           sample_valid_out,
  output logic                                           overrun_out
`ifdef MIXER_EN
  ,
  output logic signed [SAMPLE_WIDTH-1:0]                 mix_out
`endif
);

  localparam int unsigned PH_W = WW_WIDTH + FRAC_WIDTH;
  // Stages T+1 .. T+1+READ_LATENCY; capture happens at the last one.
  localparam int unsigned PIPE = 1 + READ_LATENCY;

  state_e state_q;
  logic   wait_q;
  logic   seen_load_q;
  logic   mute_now;

  logic [PIPE-1:0]            pipe_q;
  logic                       valid_q;
  logic                       overrun_q;
  logic                       zero_q;
  logic [NUM_OSCILLATORS-1:0] mask_q;
  logic                       busy;
  logic                       tick_accept;

  logic signed [SAMPLE_WIDTH-1:0] cap      [NUM_OSCILLATORS];
  logic signed [SAMPLE_WIDTH-1:0] sample_q [NUM_OSCILLATORS];

  // A reload request overrides the current state in the very cycle it arrives.
  assign mute_now    = reload_in | loading_in | (state_q == MUTE);
  assign busy        = (|pipe_q) | valid_q;
  assign tick_accept = sample_tick_in & ~busy;

  // Control FSM: leave MUTE once the loader has finished, or after a short
  // grace period if the loader never started.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= MUTE;
      wait_q      <= 1'b0;
      seen_load_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (reload_in || loading_in) begin
            state_q     <= MUTE;
            wait_q      <= 1'b0;
            seen_load_q <= loading_in;
          end
        end
        default: begin
          if (reload_in) begin
            wait_q      <= 1'b0;
            seen_load_q <= 1'b0;
          end else if (loading_in) begin
            seen_load_q <= 1'b1;
          end else if (seen_load_q || wait_q) begin
            state_q <= RUN;
          end else begin
            wait_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Per-oscillator accumulators and address / sample port mapping.
  for (genvar g = 0; g < NUM_OSCILLATORS; g++) begin : g_osc
    phase_acc #(
      .WW_WIDTH  (WW_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH)
    ) u_acc (
      .clk       (clk_in),
      .rst       (rst_in),
      .clear     (mute_now),
      .advance   (tick_accept),
      .enable    (osc_is_on_in[g]),
      .step      (osc_step_in[g*PH_W +: PH_W]),
      .wave_width(wave_width_in),
      .index     (osc_index_out[g*WW_WIDTH +: WW_WIDTH])
    );
    assign osc_sample_out[g*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_q[g];
  end

  // Capture values: zero if muted at any point in flight or osc masked at tick.
  always_comb begin
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      cap[i] = '0;
      if (!zero_q && !mute_now && mask_q[i]) begin
        cap[i] = osc_data_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  // Tick pipeline, sample capture, valid strobe and sticky overrun.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      zero_q    <= 1'b0;
      mask_q    <= '0;
      for (int i = 0; i < NUM_OSCILLATORS; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      pipe_q    <= {pipe_q[PIPE-2:0], tick_accept};
      valid_q   <= pipe_q[PIPE-1];
      overrun_q <= overrun_q | (sample_tick_in & busy);
      if (tick_accept) begin
        zero_q <= mute_now;
        mask_q <= osc_is_on_in & {NUM_OSCILLATORS{wave_width_in != '0}};
      end else if (mute_now) begin
        zero_q <= 1'b1;
      end
      if (pipe_q[PIPE-1]) begin
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
          sample_q[i] <= cap[i];
        end
      end
    end
  end

  assign sample_valid_out = valid_q;
  assign overrun_out      = overrun_q;

`ifdef MIXER_EN
  localparam int unsigned MIX_SH = $clog2(NUM_OSCILLATORS);

  logic signed [SAMPLE_WIDTH+MIX_SH-1:0] mix_sum;
  logic signed [SAMPLE_WIDTH-1:0]        mix_q;

  // Sign-extended sum of the captured (already masked) samples.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_OSCILLATORS; i++) begin
      mix_sum = mix_sum + (SAMPLE_WIDTH + MIX_SH)'(cap[i]);
    end
  end

  // Mix register, updated together with the per-oscillator samples.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mix_q <= '0;
    end else if (pipe_q[PIPE-1]) begin
      mix_q <= SAMPLE_WIDTH'(mix_sum >>> MIX_SH);
    end
  end

  assign mix_out = mix_q;
`endif

endmodule

// File: tb/tb_wavetable_player.sv
// Directed self-checking bench for wavetable_player with a 2-cycle BRAM model.
module tb_wavetable_player;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int WW = 18;
  localparam int PH = 30;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            sample_tick_in;
  logic [WW-1:0]   wave_width_in;
  logic            reload_in;
  logic            loading_in;
  logic [N-1:0]    osc_is_on_in;
  logic [N*PH-1:0] osc_step_in;
  logic [N*WW-1:0] osc_index_out;
  logic [N*SW-1:0] osc_data_in;
  logic [N*SW-1:0] osc_sample_out;
  logic            sample_valid_out;
  logic            overrun_out;
`ifdef MIXER_EN
  logic signed [SW-1:0] mix_out;
`endif

  int errors = 0;
  int checks = 0;

  logic            fixed_mode;
  logic [N*WW-1:0] addr_q;

  always #5 clk_in = ~clk_in;

  wavetable_player dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_tick_in  (sample_tick_in),
    .wave_width_in   (wave_width_in),
    .reload_in       (reload_in),
    .loading_in      (loading_in),
    .osc_is_on_in    (osc_is_on_in),
    .osc_step_in     (osc_step_in),
    .osc_index_out   (osc_index_out),
    .osc_data_in     (osc_data_in),
    .osc_sample_out  (osc_sample_out),
    .sample_valid_out(sample_valid_out),
    .overrun_out     (overrun_out)
`ifdef MIXER_EN
    ,
    .mix_out         (mix_out)
`endif
  );

  // BRAM contents: word = 0x1000*(osc+1) + address; fixed mode gives mixer values.
  function automatic logic [SW-1:0] bram_word(input int i, input logic [WW-1:0] a);
    logic [SW-1:0] fixed_vals [N];
    fixed_vals[0] = 16'h4000;
    fixed_vals[1] = 16'h4000;
    fixed_vals[2] = 16'he000;
    fixed_vals[3] = 16'h0000;
    if (fixed_mode) return fixed_vals[i];
    return SW'((i + 1) * 4096) + a[SW-1:0];
  endfunction

  // Two-cycle registered read.
  always @(posedge clk_in) begin
    addr_q <= osc_index_out;
    for (int i = 0; i < N; i++) begin
      osc_data_in[i*SW +: SW] <= bram_word(i, addr_q[i*WW +: WW]);
    end
  end

  task automatic do_reset();
    rst_in = 1'b1;
    sample_tick_in = 1'b0;
    reload_in = 1'b0;
    loading_in = 1'b0;
    fixed_mode = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  // One tick; returns index at T+1, any valid seen in T+1..T+3, valid and samples at T+4.
  task automatic run_tick(input logic rl, input logic start_ld, output logic [N*WW-1:0] idx,
                          output logic early, output logic vld, output logic [N*SW-1:0] smp);
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    reload_in = rl;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    reload_in = 1'b0;
    if (start_ld) loading_in = 1'b1;
    idx = osc_index_out;
    early = sample_valid_out;
    repeat (2) begin
      @(negedge clk_in);
      early = early | sample_valid_out;
    end
    @(negedge clk_in);
    vld = sample_valid_out;
    smp = osc_sample_out;
    repeat (5) @(negedge clk_in);
  endtask

  task automatic set_step(input int i, input logic [PH-1:0] s);
    osc_step_in[i*PH +: PH] = s;
  endtask

  task automatic test_reset();
    wave_width_in = 18'd256;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'h1000);
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (osc_index_out !== '0) begin
      errors++;
      $display("FAIL reset_index got %0h want 0", osc_index_out);
    end
    checks++;
    if (osc_sample_out !== '0) begin
      errors++;
      $display("FAIL reset_sample got %0h want 0", osc_sample_out);
    end
    checks++;
    if (sample_valid_out !== 1'b0 || overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b overrun=%b want 0 0", sample_valid_out, overrun_out);
    end
    do_reset();
  endtask

  task automatic test_step_one();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    wave_width_in = 18'd256;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'h1000);
    do_reset();
    for (int k = 1; k <= 300; k++) begin
      run_tick(1'b0, 1'b0, idx, early, vld, smp);
      checks++;
      if (idx[WW-1:0] !== WW'(k % 256)) begin
        errors++;
        $display("FAIL step1_index k=%0d got %0d want %0d", k, idx[WW-1:0], k % 256);
      end
      checks++;
      if (early !== 1'b0 || vld !== 1'b1) begin
        errors++;
        $display("FAIL step1_valid k=%0d got early=%b vld=%b want 0 1", k, early, vld);
      end
      checks++;
      if (smp[SW-1:0] !== SW'(16'h1000 + (k % 256)) || smp[2*SW-1:SW] !== '0) begin
        errors++;
        $display("FAIL step1_sample k=%0d got %0h want %0h/0", k, smp[2*SW-1:0],
                 16'h1000 + (k % 256));
      end
    end
  endtask

  task automatic test_frac_step();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    int exp_idx;
    wave_width_in = 18'd10;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'h1800);
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      run_tick(1'b0, 1'b0, idx, early, vld, smp);
      exp_idx = ((3 * k) % 20) / 2;
      checks++;
      if (idx[WW-1:0] !== WW'(exp_idx) || smp[SW-1:0] !== SW'(16'h1000 + exp_idx)) begin
        errors++;
        $display("FAIL frac_index k=%0d got idx=%0d smp=%0h want idx=%0d", k, idx[WW-1:0],
                 smp[SW-1:0], exp_idx);
      end
    end
    // Zero wave width: index held 0, sample forced 0, valid kept.
    wave_width_in = '0;
    run_tick(1'b0, 1'b0, idx, early, vld, smp);
    checks++;
    if (idx[WW-1:0] !== '0 || smp[SW-1:0] !== '0 || vld !== 1'b1) begin
      errors++;
      $display("FAIL width0 got idx=%0d smp=%0h vld=%b want 0 0 1", idx[WW-1:0], smp[SW-1:0],
               vld);
    end
  endtask

  task automatic test_wrap_limits();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    logic [WW-1:0] exp_tab [9];
    exp_tab = '{18'd2, 18'd4, 18'd0, 18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd2};
    wave_width_in = 18'd10;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'hC000);
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k == 2) set_step(0, 30'h19000);
      if (k == 3) set_step(0, 30'h1000);
      if (k == 8) wave_width_in = 18'd4;
      run_tick(1'b0, 1'b0, idx, early, vld, smp);
      checks++;
      if (idx[WW-1:0] !== exp_tab[k]) begin
        errors++;
        $display("FAIL wrap_index step=%0d got %0d want %0d", k, idx[WW-1:0], exp_tab[k]);
      end
    end
  endtask

  task automatic test_reload();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    wave_width_in = 18'd256;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'h1000);
    do_reset();
    repeat (5) run_tick(1'b0, 1'b0, idx, early, vld, smp);
    checks++;
    if (idx[WW-1:0] !== 18'd5) begin
      errors++;
      $display("FAIL reload_pre got %0d want 5", idx[WW-1:0]);
    end
    // Reload coincident with a tick, then loader busy across further ticks.
    for (int k = 0; k < 3; k++) begin
      run_tick(k == 0, k == 0, idx, early, vld, smp);
      checks++;
      if (idx[WW-1:0] !== '0 || smp !== '0 || vld !== 1'b1) begin
        errors++;
        $display("FAIL reload_mute k=%0d got idx=%0d smp=%0h vld=%b want 0 0 1", k,
                 idx[WW-1:0], smp, vld);
      end
    end
    loading_in = 1'b0;
    repeat (2) @(negedge clk_in);
    run_tick(1'b0, 1'b0, idx, early, vld, smp);
    checks++;
    if (idx[WW-1:0] !== 18'd1 || smp[SW-1:0] !== 16'h1001) begin
      errors++;
      $display("FAIL reload_restart got idx=%0d smp=%0h want 1 1001", idx[WW-1:0], smp[SW-1:0]);
    end
    // Reload pulse while a sample is in flight; loader never starts.
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    @(negedge clk_in);
    sample_tick_in = 1'b0;
    @(negedge clk_in);
    reload_in = 1'b1;
    @(negedge clk_in);
    reload_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (sample_valid_out !== 1'b1 || osc_sample_out !== '0) begin
      errors++;
      $display("FAIL reload_inflight got vld=%b smp=%0h want 1 0", sample_valid_out,
               osc_sample_out);
    end
    repeat (3) @(negedge clk_in);
    run_tick(1'b0, 1'b0, idx, early, vld, smp);
    checks++;
    if (idx[WW-1:0] !== 18'd1 || smp[SW-1:0] !== 16'h1001) begin
      errors++;
      $display("FAIL reload_noload got idx=%0d smp=%0h want 1 1001", idx[WW-1:0], smp[SW-1:0]);
    end
  endtask

  task automatic test_overrun();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    int vcount;
    wave_width_in = 18'd256;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'h1000);
    do_reset();
    vcount = 0;
    @(negedge clk_in);
    sample_tick_in = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      sample_tick_in = (c == 2);
      if (sample_valid_out === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 1) begin
      errors++;
      $display("FAIL overrun_pulses got %0d want 1", vcount);
    end
    checks++;
    if (overrun_out !== 1'b1 || osc_index_out[WW-1:0] !== 18'd1) begin
      errors++;
      $display("FAIL overrun_flag got ovr=%b idx=%0d want 1 1", overrun_out,
               osc_index_out[WW-1:0]);
    end
    run_tick(1'b0, 1'b0, idx, early, vld, smp);
    checks++;
    if (overrun_out !== 1'b1 || idx[WW-1:0] !== 18'd2 || vld !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky got ovr=%b idx=%0d vld=%b want 1 2 1", overrun_out,
               idx[WW-1:0], vld);
    end
  endtask

  task automatic test_osc_enable();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    logic [N-1:0] on_tab  [5];
    logic [WW-1:0] exp1   [5];
    logic [SW-1:0] exp_s1 [5];
    on_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
    exp1   = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd0};
    exp_s1 = '{16'h0, 16'h0, 16'h0, 16'h2001, 16'h0};
    wave_width_in = 18'd256;
    osc_is_on_in = 4'b0001;
    osc_step_in = '0;
    set_step(0, 30'h1000);
    set_step(1, 30'h1000);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      osc_is_on_in = on_tab[k];
      run_tick(1'b0, 1'b0, idx, early, vld, smp);
      checks++;
      if (idx[WW-1:0] !== WW'(k + 1) || smp[SW-1:0] !== SW'(16'h1001 + k)) begin
        errors++;
        $display("FAIL enable_osc0 k=%0d got idx=%0d smp=%0h want %0d %0h", k, idx[WW-1:0],
                 smp[SW-1:0], k + 1, 16'h1001 + k);
      end
      checks++;
      if (idx[2*WW-1:WW] !== exp1[k] || smp[2*SW-1:SW] !== exp_s1[k]) begin
        errors++;
        $display("FAIL enable_osc1 k=%0d got idx=%0d smp=%0h want %0d %0h", k,
                 idx[2*WW-1:WW], smp[2*SW-1:SW], exp1[k], exp_s1[k]);
      end
    end
  endtask

`ifdef MIXER_EN
  task automatic test_mixer();
    logic [N*WW-1:0] idx;
    logic early, vld;
    logic [N*SW-1:0] smp;
    wave_width_in = 18'd256;
    osc_is_on_in = 4'b1111;
    osc_step_in = '0;
    do_reset();
    checks++;
    if (mix_out !== '0) begin
      errors++;
      $display("FAIL mix_reset got %0h want 0", mix_out);
    end
    fixed_mode = 1'b1;
    run_tick(1'b0, 1'b0, idx, early, vld, smp);
    checks++;
    if (mix_out !== 16'sh1800 || vld !== 1'b1) begin
      errors++;
      $display("FAIL mix_sum got %0h vld=%b want 1800 1", mix_out, vld);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_step_one();
    test_frac_step();
    test_wrap_limits();
    test_reload();
    test_overrun();
    test_osc_enable();
`ifdef MIXER_EN
    test_mixer();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
